// File: rtl/sfifo_dpram.sv
// Simple dual-port RAM, DEPTH x WIDTH.
// Synchronous write port; registered read port whose output resets to zero.
module sfifo_dpram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sfifo.sv
// Single-clock FIFO with registered read data.
// Flags come from binary pointers carrying one extra wrap bit.
module sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic             rinc,
    input  logic [WIDTH-1:0] wdata,
    output logic             wfull,
    output logic             rempty,
    output logic [WIDTH-1:0] rdata
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wptr_q;
    logic [ADDR_W:0] wptr_d;
    logic [ADDR_W:0] rptr_q;
    logic [ADDR_W:0] rptr_d;
    logic            wen;
    logic            ren;

    // Equal addresses with differing wrap bits means a full lap apart.
    assign rempty = (wptr_q == rptr_q);
    assign wfull  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                    (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

    assign wen = winc & ~wfull;
    assign ren = rinc & ~rempty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wen) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (ren) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    sfifo_dpram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .waddr  (wptr_q[ADDR_W-1:0]),
        .wdata  (wdata),
        .ren    (ren),
        .raddr  (rptr_q[ADDR_W-1:0]),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_sfifo.sv
// Self-checking bench for sfifo: vector table plus a queue-based
// reference model for fill, drain, wrap and reset sequences.
module tb_sfifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst_n;
    logic             winc;
    logic             rinc;
    logic [WIDTH-1:0] wdata;
    logic             wfull;
    logic             rempty;
    logic [WIDTH-1:0] rdata;

    sfifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .winc   (winc),
        .rinc   (rinc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rempty (rempty),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             w;
        logic             r;
        logic [WIDTH-1:0] d;
        logic             e_empty;
        logic             e_full;
        logic [WIDTH-1:0] e_rdata;
    } vec_t;

    int n_chk;
    int n_pass;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_rd;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("rdata", 32'(rdata), 32'(exp_rd));
        check("rempty", 32'(rempty), 32'(sb.size() == 0));
        check("wfull", 32'(wfull), 32'(sb.size() == DEPTH));
    endtask

    // One clock: drive, update the model at the edge, check after it.
    task automatic step(input logic w, input logic r,
                        input logic [WIDTH-1:0] d);
        bit do_w;
        bit do_r;
        do_w  = w && (sb.size() != DEPTH);
        do_r  = r && (sb.size() != 0);
        winc  = w;
        rinc  = r;
        wdata = d;
        @(posedge clk);
        if (do_r) exp_rd = sb.pop_front();
        if (do_w) sb.push_back(d);
        #1;
        winc  = 1'b0;
        rinc  = 1'b0;
        check_model();
    endtask

    vec_t tbl[8];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        exp_rd = '0;
        rst_n  = 1'b0;
        winc   = 1'b0;
        rinc   = 1'b0;
        wdata  = '0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 3; i++) begin
            winc  = 1'($urandom_range(0, 1));
            rinc  = 1'($urandom_range(0, 1));
            wdata = WIDTH'($urandom);
            @(posedge clk);
            #1;
            check("rst_empty", 32'(rempty), 32'd1);
            check("rst_full", 32'(wfull), 32'd0);
            check("rst_rdata", 32'(rdata), 32'd0);
        end
        winc = 1'b0;
        rinc = 1'b0;
        #2 rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        // Empty reads, single write/read, simultaneous at empty.
        tbl[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5};
        tbl[6] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d);
            check($sformatf("vec%0d_empty", i), 32'(rempty),
                  32'(tbl[i].e_empty));
            check($sformatf("vec%0d_full", i), 32'(wfull),
                  32'(tbl[i].e_full));
            check($sformatf("vec%0d_rdata", i), 32'(rdata),
                  32'(tbl[i].e_rdata));
        end

        // Fill to full, then a dropped write.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, WIDTH'(i));
            check("fill_empty", 32'(rempty), 32'd0);
            check("fill_full", 32'(wfull), 32'(i == DEPTH - 1));
        end
        step(1'b1, 1'b0, 8'd17);
        check("drop_full", 32'(wfull), 32'd1);

        // Drain in order, then an extra read holds the last word.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("drain_data", 32'(rdata), 32'(i));
        end
        check("drain_empty", 32'(rempty), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check("drain_hold", 32'(rdata), 32'd15);

        // Occupancy 5, then 20 simultaneous cycles across the wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(8'h40 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, WIDTH'($urandom));
        check("simul_occ", 32'(sb.size()), 32'd5);
        while (sb.size() != 0) step(1'b0, 1'b1, 8'h00);

        // Full plus simultaneous request: read only, full drops.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(8'h80 + i));
        step(1'b1, 1'b1, 8'hEE);
        check("full_rw_data", 32'(rdata), 32'h80);
        check("full_rw_full", 32'(wfull), 32'd0);
        while (sb.size() != 0) step(1'b0, 1'b1, 8'h00);
        check("full_rw_last", 32'(rdata), 32'h8F);

        // Asynchronous reset between edges at occupancy 7.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, WIDTH'(8'hC0 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hC7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(rempty), 32'd1);
        check("mid_rst_full", 32'(wfull), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        sb.delete();
        exp_rd = '0;
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_data", 32'(rdata), 32'h5A);
        check("post_rst_empty", 32'(rempty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
